// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the step clock controller.
package step_ctrl_pkg;

    // Controller modes: held in datapath reset, halted, or stepping at a rate.
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_STOP  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // Button positions in button_n / btn_level.
    localparam int BTN_RST  = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_STEP = 2;
    localparam int NUM_BTN  = 3;

    // Width of the displayed step counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: invert, 2-flop synchronise, debounce, rising-edge detect.
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic level,
    output logic press
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic            level_d_r;
    logic [DB_W-1:0] cnt_r;
    logic            press_s;

    // Bring the raw active-low button into the clock domain as an active-high level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= ~button_n;
            sync2_r <= sync1_r;
        end
    end

    // Flip the level only after the synchronised input has disagreed for DB_CYCLES cycles in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r   <= DB_W'(0);
            level_r <= 1'b0;
        end else if (sync2_r != level_r) begin
            if (cnt_r == DB_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= DB_W'(0);
            end else begin
                cnt_r <= cnt_r + DB_W'(1);
            end
        end else begin
            cnt_r <= DB_W'(0);
        end
    end

    // Remember the previous debounced level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
        end
    end

    // A press is the first cycle of a debounced high level.
    always_comb begin
        press_s = level_r & ~level_d_r;
    end

    assign level = level_r;
    assign press = press_s;

endmodule

// File: rtl/step_clock_ctrl.sv
// Step/run clock-enable generator and stretched datapath reset for the LEGv8 harness.
module step_clock_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES  = 500000,
    parameter int RST_HOLD   = 16,
    parameter int RATE_SHIFT = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       button_n,
    input  logic [3:0]       run_rate,
    output logic             step_en,
    output logic             dp_reset,
    output logic             running,
    output logic [2:0]       btn_level,
    output logic [CNT_W-1:0] step_count
);

    localparam int HOLD_W = $clog2(RST_HOLD + 2);
    localparam int RATE_W = RATE_SHIFT + 16;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

    // Terminal count of the run-mode rate counter: 2^(rate+RATE_SHIFT) - 1.
    function automatic logic [RATE_W-1:0] rate_limit(input logic [3:0] rate);
        logic [RATE_W-1:0] one_v;
        one_v = {{(RATE_W-1){1'b0}}, 1'b1};
        return (one_v << (32'(rate) + RATE_SHIFT)) - one_v;
    endfunction

    logic [NUM_BTN-1:0] level_s;
    logic [NUM_BTN-1:0] press_s;

    state_t              state_r;
    state_t              state_nx_s;
    logic [HOLD_W-1:0]   hold_r;
    logic [HOLD_W-1:0]   hold_nx_s;
    logic [RATE_W-1:0]   rate_r;
    logic [RATE_W-1:0]   rate_nx_s;
    logic [RATE_W-1:0]   rate_lim_s;
    logic                step_nx_s;
    logic                step_en_r;
    logic                dp_reset_r;
    logic                running_r;
    logic [CNT_W-1:0]    step_cnt_r;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_btn (
            .clock    (clock),
            .reset    (reset),
            .button_n (button_n[i]),
            .level    (level_s[i]),
            .press    (press_s[i])
        );
    end

    // Current run-rate terminal count, so a rate change takes effect on the next cycle.
    always_comb begin
        rate_lim_s = rate_limit(run_rate);
    end

    // Next-state logic: reset button dominates, toggle beats step, steps ignored while running.
    always_comb begin
        state_nx_s = state_r;
        hold_nx_s  = hold_r;
        rate_nx_s  = rate_r;
        step_nx_s  = 1'b0;
        if (level_s[BTN_RST]) begin
            state_nx_s = S_RESET;
            hold_nx_s  = HOLD_INIT;
            rate_nx_s  = RATE_W'(0);
        end else begin
            case (state_r)
                S_RESET: begin
                    rate_nx_s = RATE_W'(0);
                    if (hold_r == HOLD_W'(0)) begin
                        state_nx_s = S_STOP;
                    end else begin
                        hold_nx_s = hold_r - HOLD_W'(1);
                    end
                end
                S_STOP: begin
                    rate_nx_s = RATE_W'(0);
                    if (press_s[BTN_RUN]) begin
                        state_nx_s = S_RUN;
                    end else if (press_s[BTN_STEP]) begin
                        step_nx_s = 1'b1;
                    end else begin
                        step_nx_s = 1'b0;
                    end
                end
                S_RUN: begin
                    if (press_s[BTN_RUN]) begin
                        state_nx_s = S_STOP;
                        rate_nx_s  = RATE_W'(0);
                    end else if (rate_r >= rate_lim_s) begin
                        step_nx_s = 1'b1;
                        rate_nx_s = RATE_W'(0);
                    end else begin
                        rate_nx_s = rate_r + RATE_W'(1);
                    end
                end
                default: begin
                    state_nx_s = S_RESET;
                    hold_nx_s  = HOLD_INIT;
                    rate_nx_s  = RATE_W'(0);
                end
            endcase
        end
    end

    // State, counters and registered outputs; dp_reset tracks the state being entered so
    // step_en (only set outside S_RESET) can never overlap it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_RESET;
            hold_r     <= HOLD_INIT;
            rate_r     <= RATE_W'(0);
            step_en_r  <= 1'b0;
            dp_reset_r <= 1'b1;
            running_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            hold_r     <= hold_nx_s;
            rate_r     <= rate_nx_s;
            step_en_r  <= step_nx_s;
            dp_reset_r <= (state_nx_s == S_RESET);
            running_r  <= (state_r == S_RUN);
        end
    end

    // Steps since the last datapath reset, wrapping naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_cnt_r <= CNT_W'(0);
        end else if (dp_reset_r) begin
            step_cnt_r <= CNT_W'(0);
        end else if (step_en_r) begin
            step_cnt_r <= step_cnt_r + CNT_W'(1);
        end else begin
            step_cnt_r <= step_cnt_r;
        end
    end

    assign step_en    = step_en_r;
    assign dp_reset   = dp_reset_r;
    assign running    = running_r;
    assign btn_level  = level_s;
    assign step_count = step_cnt_r;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Scoreboard bench for step_clock_ctrl: stimulus predicts step times, a monitor checks them.
module tb_step_clock_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 3;
    localparam int RS   = 1;
    localparam int LAT  = DB + 3;   // button drive to step_en, in clock cycles

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  button_n = 3'b111;
    logic [3:0]  run_rate = 4'd0;
    logic        step_en;
    logic        dp_reset;
    logic        running;
    logic [2:0]  btn_level;
    logic [15:0] step_count;

    step_clock_ctrl #(
        .DB_CYCLES  (DB),
        .RST_HOLD   (HOLD),
        .RATE_SHIFT (RS)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .button_n   (button_n),
        .run_rate   (run_rate),
        .step_en    (step_en),
        .dp_reset   (dp_reset),
        .running    (running),
        .btn_level  (btn_level),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Edge counter: between edges, cyc is the number of the last rising edge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned edge_n;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_cnt = 16'd0;

    // Run-mode model: steps land every 2^(rate+RS) edges after entry / last step.
    bit          run_active = 1'b0;
    int unsigned run_n = 0;
    int unsigned next_fire = 0;
    int unsigned run_stop_edge = 32'hFFFF_FFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_step(input int unsigned at);
        exp_t e;
        e.edge_n = at;
        e.cnt    = model_cnt;
        exp_q.push_back(e);
        model_cnt = model_cnt + 16'd1;
    endtask

    // Predict run-mode steps for the coming edge, then advance one cycle.
    task automatic tick();
        if (run_active) begin
            if (cyc + 1 >= run_stop_edge) begin
                run_active = 1'b0;
            end else if (next_fire == cyc + 1) begin
                push_step(cyc + 1);
                next_fire = next_fire + (1 << run_n);
            end
        end
        @(negedge clk);
    endtask

    task automatic tick_to(input int unsigned n);
        for (int k = 0; k < 2000; k++) begin
            if (cyc >= n) break;
            tick();
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL tick_to: reached cycle %0d, wanted %0d", cyc, n);
        end
    endtask

    // Change the rate; the counter keeps its value and is compared against the new limit.
    task automatic set_rate(input int r);
        int unsigned base;
        int unsigned nf;
        run_rate = 4'(r);
        if (run_active) begin
            base  = next_fire - (1 << run_n);
            run_n = r + RS;
            nf    = base + (1 << run_n);
            next_fire = (nf > cyc + 1) ? nf : cyc + 1;
        end else begin
            run_n = r + RS;
        end
    endtask

    task automatic press(input int idx, input int hold, input int gap);
        button_n[idx] = 1'b0;
        repeat (hold) tick();
        button_n[idx] = 1'b1;
        repeat (gap) tick();
    endtask

    // Toggle press from S_STOP: RUN is entered LAT edges after the drive.
    task automatic start_run();
        int unsigned c;
        c = cyc;
        button_n[1]   = 1'b0;
        run_active    = 1'b1;
        run_stop_edge = 32'hFFFF_FFFF;
        next_fire     = c + LAT + (1 << run_n);
        tick_to(c + LAT);
        check("running_before_entry", 32'(running), 32'd0);
        tick_to(c + LAT + 1);
        check("running_after_entry", 32'(running), 32'd1);
        tick_to(c + 10);
        button_n[1] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic stop_run();
        int unsigned c;
        c = cyc;
        run_stop_edge = c + LAT;
        button_n[1] = 1'b0;
        tick_to(c + LAT);
        check("running_before_stop", 32'(running), 32'd1);
        tick_to(c + LAT + 1);
        check("running_after_stop", 32'(running), 32'd0);
        tick_to(c + 10);
        button_n[1] = 1'b1;
        repeat (12) tick();
    endtask

    // Monitor: compare step_en and step_count against the head of the expectation queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_now;
        while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
            checks++;
            failures++;
            $display("FAIL step_missed: no step at cycle %0d, expected step_en=1", exp_q[0].edge_n);
            e = exp_q.pop_front();
        end
        exp_now = (exp_q.size() > 0) && (exp_q[0].edge_n == cyc);
        check("step_en", 32'(step_en), 32'(exp_now));
        check("step_en_with_dp_reset", 32'(step_en & dp_reset), 32'd0);
        if (exp_now) begin
            e = exp_q.pop_front();
            check("step_count_at_step", 32'(step_count), 32'(e.cnt));
        end
    end

    initial begin : stimulus
        int unsigned c;
        int unsigned r;
        int unsigned f;
        @(negedge clk);

        // Power-on reset and the stretched datapath reset.
        repeat (2) tick();
        check("reset_dp_reset", 32'(dp_reset), 32'd1);
        check("reset_running", 32'(running), 32'd0);
        check("reset_btn_level", 32'(btn_level), 32'd0);
        check("reset_step_count", 32'(step_count), 32'd0);
        c = cyc;
        reset = 1'b0;
        tick_to(c + HOLD);
        check("dp_reset_held", 32'(dp_reset), 32'd1);
        tick_to(c + HOLD + 1);
        check("dp_reset_released", 32'(dp_reset), 32'd0);
        check("stop_step_count", 32'(step_count), 32'd0);
        check("stop_running", 32'(running), 32'd0);

        // Glitch shorter than the debounce window, then one clean step.
        press(2, 3, 10);
        check("glitch_btn_level", 32'(btn_level), 32'd0);
        push_step(cyc + LAT);
        press(2, 10, 10);
        check("single_step_count", 32'(step_count), 32'd1);

        // Random mix of glitches and single steps in S_STOP.
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) press(2, $urandom_range(1, 3), $urandom_range(8, 12));
            push_step(cyc + LAT);
            press(2, $urandom_range(5, 12), $urandom_range(8, 12));
        end
        check("stop_steps_count", 32'(step_count), 32'(model_cnt));

        // Run at rate 0, speed change to rate 2, ignored step press, rate drop 3 -> 0, stop.
        set_rate(0);
        start_run();
        repeat (10) tick();
        set_rate(2);
        repeat (30) tick();
        press(2, 8, 10);
        set_rate(3);
        f = next_fire;
        tick_to(f);
        tick_to(f + 10);
        set_rate(0);
        tick();
        check("rate_drop_step", 32'(step_en), 32'd1);
        repeat (9) tick();
        stop_run();
        repeat (20) tick();

        // Randomised run sessions.
        for (int i = 0; i < 2; i++) begin
            set_rate($urandom_range(0, 2));
            start_run();
            repeat ($urandom_range(5, 25)) tick();
            set_rate($urandom_range(0, 2));
            repeat ($urandom_range(5, 25)) tick();
            stop_run();
            repeat (5) tick();
        end

        // Toggle and step debounce in the same cycle: toggle wins.
        set_rate(0);
        c = cyc;
        button_n[1] = 1'b0;
        button_n[2] = 1'b0;
        run_active    = 1'b1;
        run_stop_edge = 32'hFFFF_FFFF;
        next_fire     = c + LAT + (1 << run_n);
        tick_to(c + LAT - 2);
        check("simul_level_early", 32'(btn_level), 32'd0);
        tick_to(c + LAT - 1);
        check("simul_level_rise", 32'(btn_level), 32'b110);
        tick_to(c + LAT + 1);
        check("simul_running", 32'(running), 32'd1);
        tick_to(c + 10);
        button_n[1] = 1'b1;
        button_n[2] = 1'b1;
        repeat (20) tick();

        // Reset button while running.
        c = cyc;
        button_n[0] = 1'b0;
        run_stop_edge = c + LAT;
        tick_to(c + LAT - 1);
        check("rst_dp_reset_early", 32'(dp_reset), 32'd0);
        tick_to(c + LAT);
        check("rst_dp_reset", 32'(dp_reset), 32'd1);
        tick_to(c + LAT + 1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_step_count", 32'(step_count), 32'd0);
        model_cnt = 16'd0;
        tick_to(c + 10);
        button_n[0] = 1'b1;
        r = cyc;
        tick_to(r + LAT + HOLD - 1);
        check("rst_hold_high", 32'(dp_reset), 32'd1);
        tick_to(r + LAT + HOLD);
        check("rst_hold_release", 32'(dp_reset), 32'd0);
        check("rst_back_stop", 32'(running), 32'd0);
        repeat (20) tick();
        check("rst_stays_stop", 32'(running), 32'd0);
        push_step(cyc + LAT);
        press(2, 8, 10);
        check("post_rst_count", 32'(step_count), 32'd1);

        // Wrap from 0xFFFF.
        force dut.step_cnt_r = 16'hFFFF;
        #1;
        release dut.step_cnt_r;
        model_cnt = 16'hFFFF;
        check("wrap_preload", 32'(step_count), 32'hFFFF);
        push_step(cyc + LAT);
        press(2, 8, 10);
        check("wrap_count", 32'(step_count), 32'h0000);

        repeat (10) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
